serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/arith_pkg.sv | 13 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the default operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and publishes diff/bout/ovf together when the last bit has been processed.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the previous result
// RUN   | one bit pair processed per edge, WIDTH edges in total
// DONE  | one-cycle done pulse; result outputs were just updated
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state;
  state_t next_state;

  // The minuend register doubles as the result accumulator: each processed
  // difference bit enters at the MSB as the minuend bit leaves at the LSB.
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             br;
  logic [CW-1:0]    cnt;

  logic fs_diff;
  logic fs_bout;
  logic last_bit;

  full_subtractor u_fs (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (br),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  assign last_bit = (cnt == LAST_BIT);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a <= a;
            sh_b <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          sh_a <= {fs_diff, sh_a[WIDTH-1:1]};
          sh_b <= {1'b0, sh_b[WIDTH-1:1]};
          br   <= fs_bout;
          // Counter parks on the last bit rather than wrapping.
          if (!last_bit) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result outputs change only on the edge that enters DONE. On that edge
  // sh_a[0]/sh_b[0] still hold the captured operand MSBs, so overflow can
  // be formed without keeping a copy of the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN && last_bit) begin
      diff <= {fs_diff, sh_a[WIDTH-1:1]};
      bout <= fs_bout;
      ovf  <= (sh_a[0] != sh_b[0]) && (fs_diff != sh_a[0]);
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with an expected-result queue.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] full;
    exp_t       e;
    full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.d  = full[W-1:0];
    e.bo = full[W];
    e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
    return e;
  endfunction

  // Drives a start request at the current time and records the expected result.
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    start = 1'b1;
    a     = x;
    b     = y;
    bin   = bi;
    sb.push_back(model(x, y, bi));
  endtask

  // Waits for done after a drive_op, checking latency, busy, output hold and result.
  task automatic wait_result(input string name, input bit disturb);
    logic [W-1:0] hd;
    logic         hb, ho;
    bit           hold_ok, busy_ok, seen;
    int           n;
    exp_t         e;
    hd = diff; hb = bout; ho = ovf;
    hold_ok = 1'b1; busy_ok = 1'b1; seen = 1'b0; n = 0;
    while (!seen && n < W + 8) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (disturb && n == 3) begin
        start = 1'b1;
        a     = ~a;
        b     = b + 8'h11;
        bin   = ~bin;
      end
      if (disturb && n == 4) start = 1'b0;
      if (done) seen = 1'b1;
      else begin
        if ({diff, bout, ovf} !== {hd, hb, ho}) hold_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      $display("FAIL %s done_timeout: no done within %0d cycles", name, n);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    passed++;
    e = sb.pop_front();
    checks++;
    if (n - 1 !== W) $display("FAIL %s latency: got %0d want %0d", name, n - 1, W);
    else passed++;
    checks++;
    if (diff !== e.d) $display("FAIL %s diff: got %h want %h", name, diff, e.d);
    else passed++;
    checks++;
    if (bout !== e.bo) $display("FAIL %s bout: got %b want %b", name, bout, e.bo);
    else passed++;
    checks++;
    if (ovf !== e.ov) $display("FAIL %s ovf: got %b want %b", name, ovf, e.ov);
    else passed++;
    checks++;
    if (!hold_ok) $display("FAIL %s hold: outputs changed before done (held %h/%b/%b)", name, hd, hb, ho);
    else passed++;
    checks++;
    if (!busy_ok) $display("FAIL %s busy: got 0 during RUN want 1", name);
    else passed++;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic bi, input bit disturb);
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) $display("FAIL %s idle: busy/done got %b want 00", name, {busy, done});
    else passed++;
    drive_op(x, y, bi);
    wait_result(name, disturb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #2;
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0)
      $display("FAIL reset_initial: got %b want 0", {busy, done, diff, bout, ovf});
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0)
      $display("FAIL reset_held: got %b want 0", {busy, done, diff, bout, ovf});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(8'h05, 8'h03, 1'b0);
    wait_result("first_after_reset", 1'b0);
  endtask

  task automatic test_directed();
    run_op("sub_neg",       8'h03, 8'h05, 1'b0, 1'b0);
    run_op("ovf_neg_pos",   8'h80, 8'h01, 1'b0, 1'b0);
    run_op("ovf_pos_neg",   8'h7F, 8'hFF, 1'b0, 1'b0);
    run_op("zero_bin",      8'h00, 8'h00, 1'b1, 1'b0);
    run_op("equal_max",     8'hFF, 8'hFF, 1'b0, 1'b0);
    run_op("bin_chain",     8'h10, 8'h0F, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_op("ignore_start", 8'h9C, 8'h27, 1'b0, 1'b1);
    run_op("after_ignore", 8'h10, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    bit done_seen;
    run_op("pre_abort", 8'h80, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(8'h12, 8'h34, 1'b1);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0)
      $display("FAIL abort_outputs: got %b want 0", {busy, done, diff, bout, ovf});
    else passed++;
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) $display("FAIL abort_no_done: got done=1 want none");
    else passed++;
    run_op("after_abort", 8'hA5, 8'h5A, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   n, cnt;
    int   t[3];
    exp_t e;
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'hC3; bin = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(a, b, bin));
    n = 0; cnt = 0;
    while (cnt < 3 && n < 3 * (W + 2) + 10) begin
      @(negedge clk);
      n++;
      if (done) begin
        t[cnt] = n;
        e = sb.pop_front();
        checks++;
        if ({diff, bout, ovf} !== {e.d, e.bo, e.ov})
          $display("FAIL b2b_result%0d: got %h/%b/%b want %h/%b/%b", cnt, diff, bout, ovf, e.d, e.bo, e.ov);
        else passed++;
        cnt++;
        if (cnt == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (cnt !== 3) begin
      $display("FAIL b2b_count: got %0d done pulses want 3", cnt);
      sb.delete();
      return;
    end
    passed++;
    checks++;
    if (t[0] - 1 !== W) $display("FAIL b2b_latency: got %0d want %0d", t[0] - 1, W);
    else passed++;
    checks++;
    if (t[1] - t[0] !== W + 2) $display("FAIL b2b_period1: got %0d want %0d", t[1] - t[0], W + 2);
    else passed++;
    checks++;
    if (t[2] - t[1] !== W + 2) $display("FAIL b2b_period2: got %0d want %0d", t[2] - t[1], W + 2);
    else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic         bi;
    for (int i = 0; i < 1000; i++) begin
      x  = W'($urandom);
      y  = W'($urandom);
      bi = 1'($urandom_range(0, 1));
      run_op("random", x, y, bi, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_serial_subtractor
